// File: rtl/puf_response_multisample.sv
// Majority-voting PUF response collector: votes SAMPLES responses per chunk and
// concatenates CHUNKS voted words into n_auth. Optional macro: PUF_UNSTABLE_COUNT_EN.
module puf_response_multisample #(
    parameter  int RESP_W  = 16,
    parameter  int SAMPLES = 5,
    parameter  int CHUNKS  = 2,
    localparam int OUT_W   = RESP_W * CHUNKS,
    localparam int CNT_W   = $clog2(SAMPLES + 1),
    localparam int UB_W    = $clog2(OUT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [RESP_W-1:0] puf_response,
    input  logic              resp_valid,
    output logic              resp_ready,
    output logic [OUT_W-1:0]  n_auth,
    output logic              n_auth_valid,
    input  logic              n_auth_ack,
    output logic              busy,
    output logic [UB_W-1:0]   unstable_bits
);

    localparam int CH_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  ones [RESP_W];
    logic [CNT_W-1:0]  sample_cnt;
    logic [CH_W-1:0]   chunk_cnt;
    logic [OUT_W-1:0]  assembly;
    logic [OUT_W-1:0]  assembly_next;
    logic [RESP_W-1:0] voted;
    logic              accept;
    logic              last_sample;
    logic              last_chunk;
    logic              begin_run;

    assign resp_ready   = (state == COLLECT);
    assign n_auth_valid = (state == DONE);
    assign busy         = (state != IDLE);

    // abort wins over both accept and ack, so it gates every state-changing event
    assign accept      = (state == COLLECT) && resp_valid && !abort;
    assign begin_run   = (state == IDLE) && start && !abort;
    assign last_sample = (sample_cnt == CNT_W'(SAMPLES - 1));
    assign last_chunk  = (chunk_cnt == CH_W'(CHUNKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (begin_run) state_next = COLLECT;
            COLLECT: begin
                if (abort)                                     state_next = IDLE;
                else if (accept && last_sample && last_chunk)  state_next = DONE;
            end
            DONE:    if (abort || n_auth_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The closing sample is folded in combinationally so the vote sees all SAMPLES bits
    always_comb begin
        voted         = '0;
        assembly_next = assembly;
        for (int i = 0; i < RESP_W; i++)
            voted[i] = (ones[i] + CNT_W'(puf_response[i])) > CNT_W'(SAMPLES / 2);
        assembly_next[int'(chunk_cnt) * RESP_W +: RESP_W] = voted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_W; i++) ones[i] <= '0;
            sample_cnt <= '0;
            chunk_cnt  <= '0;
            assembly   <= '0;
            n_auth     <= '0;
        end else if (begin_run) begin
            for (int i = 0; i < RESP_W; i++) ones[i] <= '0;
            sample_cnt <= '0;
            chunk_cnt  <= '0;
            assembly   <= '0;
        end else if (accept) begin
            if (last_sample) begin
                for (int i = 0; i < RESP_W; i++) ones[i] <= '0;
                sample_cnt <= '0;
                assembly   <= assembly_next;
                chunk_cnt  <= last_chunk ? '0 : chunk_cnt + CH_W'(1);
                if (last_chunk) n_auth <= assembly_next;
            end else begin
                for (int i = 0; i < RESP_W; i++) ones[i] <= ones[i] + CNT_W'(puf_response[i]);
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PUF_UNSTABLE_COUNT_EN
    logic [UB_W-1:0]  unstable_acc;
    logic [UB_W-1:0]  chunk_unstable;
    logic [CNT_W-1:0] final_cnt;

    // A bit is unstable when its samples were not unanimous
    always_comb begin
        chunk_unstable = '0;
        final_cnt      = '0;
        for (int i = 0; i < RESP_W; i++) begin
            final_cnt = ones[i] + CNT_W'(puf_response[i]);
            if (final_cnt != '0 && final_cnt != CNT_W'(SAMPLES))
                chunk_unstable = chunk_unstable + UB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unstable_acc  <= '0;
            unstable_bits <= '0;
        end else if (begin_run) begin
            unstable_acc <= '0;
        end else if (accept && last_sample) begin
            unstable_acc <= unstable_acc + chunk_unstable;
            if (last_chunk) unstable_bits <= unstable_acc + chunk_unstable;
        end
    end
`else
    assign unstable_bits = '0;
`endif

endmodule

// File: doc/puf_response_multisample.md
# puf_response_multisample

Parametrised successor to the single-shot PUF response converter. It collects `SAMPLES` raw PUF responses per chunk through a valid/ready handshake and majority-votes each bit. It then concatenates `CHUNKS` voted words into one wide authentication number `n_auth`, with an optional count of unstable bits. It sits between the PUF array readout and the authentication/key-derivation logic.

## Interface
- `RESP_W`, 16, width of one raw PUF response.
- `SAMPLES`, 5, responses voted per chunk; must be odd and ≥1.
- `CHUNKS`, 2, number of voted words concatenated into `n_auth`.
- Derived, not overridable:
  - `OUT_W = RESP_W*CHUNKS`.
  - `CNT_W = $clog2(SAMPLES+1)`.
  - `UB_W = $clog2(OUT_W+1)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a conversion; sampled only in IDLE.
- `abort`  in  1  synchronous cancel, returns to IDLE.
- `puf_response`  in  RESP_W  raw response data.
- `resp_valid`  in  1  `puf_response` is valid.
- `resp_ready`  out  1  block accepts a response this cycle.
- `n_auth`  out  OUT_W  voted authentication number.
- `n_auth_valid`  out  1  `n_auth` is new and awaiting ack.
- `n_auth_ack`  in  1  consumer has taken `n_auth`.
- `busy`  out  1  state ≠ IDLE.
- `unstable_bits`  out  UB_W  count of non-unanimous bits (see Configuration).

## Operation
- **FSM states**: IDLE, COLLECT, DONE.
- **IDLE**:
  - `resp_ready`=0.
  - `start`=1 → COLLECT; clears the per-bit ones counters, sample counter, chunk counter, assembly register and unstable accumulator.
- **COLLECT**:
  - `resp_ready`=1.
  - On accept (`resp_valid`&`resp_ready`): each bit's ones counter (`CNT_W` bits) adds `puf_response[i]`, and the sample counter increments.
  - The accept with sample counter = `SAMPLES-1` closes the chunk:
    - Voted bit i = (ones_i + current bit) > `SAMPLES/2` (integer division).
    - The voted word is written to assembly bits [chunk*RESP_W +: RESP_W]; chunk 0 occupies the LSBs.
    - Unstable accumulator adds the number of bits whose final count is neither 0 nor `SAMPLES`.
    - Ones and sample counters clear; the chunk counter increments.
  - Closing chunk `CHUNKS-1` → DONE. On that edge, `n_auth` ← assembly (including the final chunk) and `unstable_bits` ← accumulator.
- **DONE**:
  - `n_auth_valid`=1, `resp_ready`=0.
  - `n_auth_ack`=1 → IDLE. `start` is ignored while in DONE.
- **`abort`**:
  - In COLLECT or DONE: → IDLE next edge. `abort` has priority over accept and ack.
  - `n_auth` and `unstable_bits` keep their previous values.
  - `abort` in IDLE has no effect; `abort` and `start` together in IDLE stays IDLE.
- `n_auth` changes only on the completion edge; partial chunks are never exposed.
- `SAMPLES`=1 degenerates to a concatenation of `CHUNKS` single responses; `unstable_bits` is always 0.

## Timing
- **Reset values**: state IDLE; `n_auth`=0, `n_auth_valid`=0, `resp_ready`=0, `busy`=0, `unstable_bits`=0; all internal counters 0.
- **Start**: `start` at edge k → `busy`=1 and `resp_ready`=1 from cycle k+1.
- **Completion**: final accept at edge m → `n_auth`, `n_auth_valid` and `unstable_bits` update at edge m; `resp_ready`=0 from cycle m+1.
- **Minimum latency**: start to `n_auth_valid` is `SAMPLES*CHUNKS`+1 cycles when `resp_valid` is held high.
- **Ack**: `n_auth_valid` drops, and `busy` drops, the cycle after `n_auth_ack` is sampled high in DONE. A new `start` is accepted from the following cycle.
- **Outputs**: all registered; no combinational path from inputs to outputs except none. `resp_ready` is decoded from the state register.
- **Reset mid-operation**: asynchronous return to the reset values; any partial conversion is discarded.

## Configuration
- Macro `PUF_UNSTABLE_COUNT_EN`.
- **Defined**: the unstable-bit accumulator is implemented; `unstable_bits` reports the count for the last completed conversion.
- **Undefined**: the accumulator logic is omitted; `unstable_bits` is tied to 0; the port remains present.

## Test plan
Parameters `RESP_W`=16, `SAMPLES`=3, `CHUNKS`=2, macro defined.

1. **Reset**: assert `rst_n`=0 mid-run → all outputs 0 immediately; release → IDLE, `resp_ready`=0.
2. **Stable input**: `start`, then 0xA5A5 ×3 and 0x1234 ×3 with `resp_valid` held high → `n_auth`=0x1234A5A5 and `n_auth_valid`=1 seven cycles after start, `unstable_bits`=0.
3. **Noisy input**:
   - Stimulus: chunk0 = 0x00FF, 0x00FE, 0x01FF; chunk1 = 0xFFFF ×3.
   - Required: `n_auth`=0xFFFF00FF, `unstable_bits`=2.
4. **Backpressure**:
   - Stimulus: `resp_valid` toggled 1/0, then `n_auth_ack` held 0 for 5 cycles with `start` pulsed meanwhile.
   - Required: result matches scenario 2; `n_auth_valid` stays 1, `start` is ignored, `resp_ready`=0; ack → IDLE next cycle.
5. **Abort**:
   - Stimulus: `abort` after the 4th accept; then a full run with 0x0001 ×6.
   - Required: `busy`=0 next cycle, `n_auth` retains its prior value, `n_auth_valid` never asserts; the new run gives `n_auth`=0x00010001.
6. **Macro undefined**: rerun scenario 3 → `n_auth`=0xFFFF00FF, `unstable_bits`=0.
